// File: rtl/regfile_operand_fetch.sv
// -----------------------------------------------------------------------------
// regfile_operand_fetch
//   Read-side client of the lane register file. It accepts issued instructions
//   and drives the register file read ports. The register file has a 1-cycle
//   registered read latency, so the returned operands are captured one cycle
//   after issue. The operands are then presented to the execution stage through
//   a registered valid/ready output stage.
//
//   The register file returns the pre-write value when a read and a write hit
//   the same register on the same edge. Write-back data seen in the issue
//   cycle is therefore snooped and forwarded in place of the stale read.
//
//   Pipeline: S1 (read in flight) -> S2 (output register).
//
// Ports
//   clock, reset                  single clock, synchronous active-high reset
//   I_Valid / O_Ready             issue handshake
//   I_Re1, I_Re2                  source-1/2 used flags
//   I_Index_Src1/2, I_Tag         source indices and opaque tag
//   O_RF_Re1/2, O_RF_Index1/2     register file read requests
//   I_RF_Data1/2                  register file read data (1 cycle after Re)
//   I_WB_We/Index/Data            snooped register file write port
//   O_Valid / I_Ready             execution-stage handshake
//   O_Src1, O_Src2, O_Tag         operands (0 when unused) and tag
// -----------------------------------------------------------------------------
module regfile_operand_fetch #(
  parameter int WIDTH_DATA  = 32,
  parameter int WIDTH_INDEX = 6,
  parameter int WIDTH_TAG   = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   I_Valid,
  output logic                   O_Ready,
  input  logic                   I_Re1,
  input  logic                   I_Re2,
  input  logic [WIDTH_INDEX-1:0] I_Index_Src1,
  input  logic [WIDTH_INDEX-1:0] I_Index_Src2,
  input  logic [WIDTH_TAG-1:0]   I_Tag,
  output logic                   O_RF_Re1,
  output logic                   O_RF_Re2,
  output logic [WIDTH_INDEX-1:0] O_RF_Index1,
  output logic [WIDTH_INDEX-1:0] O_RF_Index2,
  input  logic [WIDTH_DATA-1:0]  I_RF_Data1,
  input  logic [WIDTH_DATA-1:0]  I_RF_Data2,
  input  logic                   I_WB_We,
  input  logic [WIDTH_INDEX-1:0] I_WB_Index,
  input  logic [WIDTH_DATA-1:0]  I_WB_Data,
  output logic                   O_Valid,
  input  logic                   I_Ready,
  output logic [WIDTH_DATA-1:0]  O_Src1,
  output logic [WIDTH_DATA-1:0]  O_Src2,
  output logic [WIDTH_TAG-1:0]   O_Tag
);

  // S1: instruction whose register file read is in flight
  logic                  s1_v_q, s1_v_d;
  logic                  s1_re1_q, s1_re1_d;
  logic                  s1_re2_q, s1_re2_d;
  logic                  s1_fwd1_q, s1_fwd1_d;
  logic                  s1_fwd2_q, s1_fwd2_d;
  // Both sources forward from the same snooped write, so one data copy suffices
  logic [WIDTH_DATA-1:0] s1_fwd_data_q, s1_fwd_data_d;
  logic [WIDTH_TAG-1:0]  s1_tag_q, s1_tag_d;

  // S2: output register presented to the execution stage
  logic                  s2_v_q, s2_v_d;
  logic [WIDTH_DATA-1:0] s2_src1_q, s2_src1_d;
  logic [WIDTH_DATA-1:0] s2_src2_q, s2_src2_d;
  logic [WIDTH_TAG-1:0]  s2_tag_q, s2_tag_d;

  logic adv1_s;
  logic issue_s;

  // Handshake and register file read request generation
  always_comb begin
    adv1_s      = s1_v_q & (~s2_v_q | I_Ready);
    // Gated by reset so no read is requested while reset is asserted
    O_Ready     = ~reset & (~s1_v_q | adv1_s);
    issue_s     = I_Valid & O_Ready;
    O_RF_Re1    = issue_s & I_Re1;
    O_RF_Re2    = issue_s & I_Re2;
    O_RF_Index1 = I_Re1 ? I_Index_Src1 : {WIDTH_INDEX{1'b0}};
    O_RF_Index2 = I_Re2 ? I_Index_Src2 : {WIDTH_INDEX{1'b0}};
  end

  // Next-state logic for S1 and S2
  always_comb begin
    s1_v_d        = s1_v_q;
    s1_re1_d      = s1_re1_q;
    s1_re2_d      = s1_re2_q;
    s1_fwd1_d     = s1_fwd1_q;
    s1_fwd2_d     = s1_fwd2_q;
    s1_fwd_data_d = s1_fwd_data_q;
    s1_tag_d      = s1_tag_q;
    s2_v_d        = s2_v_q;
    s2_src1_d     = s2_src1_q;
    s2_src2_d     = s2_src2_q;
    s2_tag_d      = s2_tag_q;

    if (issue_s) begin
      s1_v_d        = 1'b1;
      s1_re1_d      = I_Re1;
      s1_re2_d      = I_Re2;
      s1_tag_d      = I_Tag;
      // Only a same-edge write needs forwarding; earlier writes are already in the file
      s1_fwd1_d     = I_Re1 & I_WB_We & (I_WB_Index == I_Index_Src1);
      s1_fwd2_d     = I_Re2 & I_WB_We & (I_WB_Index == I_Index_Src2);
      s1_fwd_data_d = I_WB_Data;
    end else if (adv1_s) begin
      s1_v_d = 1'b0;
    end else begin
      // Stalled: no new reads are issued, so the register file output holds the operand
      s1_v_d = s1_v_q;
    end

    if (adv1_s) begin
      s2_v_d    = 1'b1;
      s2_tag_d  = s1_tag_q;
      s2_src1_d = ~s1_re1_q ? {WIDTH_DATA{1'b0}} : (s1_fwd1_q ? s1_fwd_data_q : I_RF_Data1);
      s2_src2_d = ~s1_re2_q ? {WIDTH_DATA{1'b0}} : (s1_fwd2_q ? s1_fwd_data_q : I_RF_Data2);
    end else if (s2_v_q & I_Ready) begin
      s2_v_d = 1'b0;
    end else begin
      s2_v_d = s2_v_q;
    end
  end

  // Pipeline state registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_v_q        <= 1'b0;
      s1_re1_q      <= 1'b0;
      s1_re2_q      <= 1'b0;
      s1_fwd1_q     <= 1'b0;
      s1_fwd2_q     <= 1'b0;
      s1_fwd_data_q <= {WIDTH_DATA{1'b0}};
      s1_tag_q      <= {WIDTH_TAG{1'b0}};
      s2_v_q        <= 1'b0;
      s2_src1_q     <= {WIDTH_DATA{1'b0}};
      s2_src2_q     <= {WIDTH_DATA{1'b0}};
      s2_tag_q      <= {WIDTH_TAG{1'b0}};
    end else begin
      s1_v_q        <= s1_v_d;
      s1_re1_q      <= s1_re1_d;
      s1_re2_q      <= s1_re2_d;
      s1_fwd1_q     <= s1_fwd1_d;
      s1_fwd2_q     <= s1_fwd2_d;
      s1_fwd_data_q <= s1_fwd_data_d;
      s1_tag_q      <= s1_tag_d;
      s2_v_q        <= s2_v_d;
      s2_src1_q     <= s2_src1_d;
      s2_src2_q     <= s2_src2_d;
      s2_tag_q      <= s2_tag_d;
    end
  end

  assign O_Valid = s2_v_q;
  assign O_Src1  = s2_src1_q;
  assign O_Src2  = s2_src2_q;
  assign O_Tag   = s2_tag_q;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_regfile_operand_fetch
//   Directed bench for regfile_operand_fetch. A behavioural register file
//   (registered reads, pre-write value on same-edge read/write) is attached.
//   A table of single-instruction vectors is applied first. Hand-written
//   sequences follow for write timing, back-to-back streaming, output stall
//   and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_regfile_operand_fetch;

  localparam int WD = 32;
  localparam int WI = 6;
  localparam int WT = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          I_Valid, O_Ready, I_Re1, I_Re2;
  logic [WI-1:0] I_Index_Src1, I_Index_Src2;
  logic [WT-1:0] I_Tag;
  logic          O_RF_Re1, O_RF_Re2;
  logic [WI-1:0] O_RF_Index1, O_RF_Index2;
  logic [WD-1:0] I_RF_Data1, I_RF_Data2;
  logic          I_WB_We;
  logic [WI-1:0] I_WB_Index;
  logic [WD-1:0] I_WB_Data;
  logic          O_Valid, I_Ready;
  logic [WD-1:0] O_Src1, O_Src2;
  logic [WT-1:0] O_Tag;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  regfile_operand_fetch #(.WIDTH_DATA(WD), .WIDTH_INDEX(WI), .WIDTH_TAG(WT)) dut (
    .clock(clock), .reset(reset),
    .I_Valid(I_Valid), .O_Ready(O_Ready), .I_Re1(I_Re1), .I_Re2(I_Re2),
    .I_Index_Src1(I_Index_Src1), .I_Index_Src2(I_Index_Src2), .I_Tag(I_Tag),
    .O_RF_Re1(O_RF_Re1), .O_RF_Re2(O_RF_Re2),
    .O_RF_Index1(O_RF_Index1), .O_RF_Index2(O_RF_Index2),
    .I_RF_Data1(I_RF_Data1), .I_RF_Data2(I_RF_Data2),
    .I_WB_We(I_WB_We), .I_WB_Index(I_WB_Index), .I_WB_Data(I_WB_Data),
    .O_Valid(O_Valid), .I_Ready(I_Ready),
    .O_Src1(O_Src1), .O_Src2(O_Src2), .O_Tag(O_Tag)
  );

  // Behavioural register file: registered reads, pre-write data on same-edge hit
  logic [WD-1:0] rf_mem [64];
  always @(posedge clock) begin
    if (O_RF_Re1) I_RF_Data1 <= rf_mem[O_RF_Index1];
    if (O_RF_Re2) I_RF_Data2 <= rf_mem[O_RF_Index2];
    if (I_WB_We)  rf_mem[I_WB_Index] <= I_WB_Data;
  end

  // wmode: 0 no write-back, 1 write in issue cycle, 2 write one cycle after issue
  typedef struct {
    logic          re1;
    logic          re2;
    logic [WI-1:0] i1;
    logic [WI-1:0] i2;
    logic [WT-1:0] tag;
    logic [1:0]    wmode;
    logic [WI-1:0] wi;
    logic [WD-1:0] wd;
    logic [WD-1:0] e1;
    logic [WD-1:0] e2;
  } vec_t;

  vec_t vt[7];
  vec_t st[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wb_write(input logic [WI-1:0] idx, input logic [WD-1:0] data);
    @(negedge clock);
    I_WB_We = 1'b1; I_WB_Index = idx; I_WB_Data = data;
    @(posedge clock); #1;
    I_WB_We = 1'b0;
  endtask

  // Issue one instruction into an empty pipeline with I_Ready high and follow it out
  task automatic apply_vec(input vec_t v, input string id);
    logic [WI-1:0] ei1, ei2;
    ei1 = v.re1 ? v.i1 : 6'd0;
    ei2 = v.re2 ? v.i2 : 6'd0;
    @(negedge clock);
    I_Ready = 1'b1; I_Valid = 1'b1;
    I_Re1 = v.re1; I_Re2 = v.re2; I_Index_Src1 = v.i1; I_Index_Src2 = v.i2; I_Tag = v.tag;
    I_WB_We = (v.wmode == 2'd1); I_WB_Index = v.wi; I_WB_Data = v.wd;
    #1;
    check({id, " O_Ready"},     32'(O_Ready),     32'd1);
    check({id, " O_RF_Re1"},    32'(O_RF_Re1),    32'(v.re1));
    check({id, " O_RF_Re2"},    32'(O_RF_Re2),    32'(v.re2));
    check({id, " O_RF_Index1"}, 32'(O_RF_Index1), 32'(ei1));
    check({id, " O_RF_Index2"}, 32'(O_RF_Index2), 32'(ei2));
    @(posedge clock); #1;
    I_Valid = 1'b0; I_Re1 = 1'b0; I_Re2 = 1'b0;
    I_WB_We = (v.wmode == 2'd2);
    check({id, " valid after 1 cycle"}, 32'(O_Valid), 32'd0);
    @(posedge clock); #1;
    I_WB_We = 1'b0;
    check({id, " O_Valid"}, 32'(O_Valid), 32'd1);
    check({id, " O_Src1"},  O_Src1,       v.e1);
    check({id, " O_Src2"},  O_Src2,       v.e2);
    check({id, " O_Tag"},   32'(O_Tag),   32'(v.tag));
    @(posedge clock); #1;
    check({id, " drained"}, 32'(O_Valid), 32'd0);
  endtask

  // Stream the instructions in st[] with an optional I_Ready-low window and one write-back
  task automatic run_stream(input int stall_start, input int stall_len, input int wb_cyc,
                            input logic [WI-1:0] wbi, input logic [WD-1:0] wbd,
                            output int rdy_low, output int acc_stall, output int first_d,
                            output int last_d, output int deliv);
    vec_t expq[$];
    vec_t h;
    int   issued;
    issued = 0; deliv = 0; rdy_low = 0; acc_stall = -1; first_d = -1; last_d = -1;
    for (int c = 0; c < 60 && deliv < st.size(); c++) begin
      @(negedge clock);
      I_Ready    = !(c >= stall_start && c < stall_start + stall_len);
      I_WB_We    = (c == wb_cyc); I_WB_Index = wbi; I_WB_Data = wbd;
      if (issued < st.size()) begin
        I_Valid = 1'b1;
        I_Re1 = st[issued].re1; I_Re2 = st[issued].re2;
        I_Index_Src1 = st[issued].i1; I_Index_Src2 = st[issued].i2; I_Tag = st[issued].tag;
      end else begin
        I_Valid = 1'b0;
      end
      #1;
      if (O_Valid) begin
        if (expq.size() == 0) begin
          check("stream spurious O_Valid", 32'(O_Valid), 32'd0);
        end else begin
          h = expq[0];
          check("stream O_Tag",  32'(O_Tag), 32'(h.tag));
          check("stream O_Src1", O_Src1,     h.e1);
          check("stream O_Src2", O_Src2,     h.e2);
          if (I_Ready) begin
            void'(expq.pop_front());
            if (first_d < 0) first_d = c;
            last_d = c;
            deliv++;
          end
        end
      end
      if (I_Valid) begin
        if (O_Ready) begin
          expq.push_back(st[issued]);
          issued++;
        end else begin
          rdy_low++;
        end
      end
      if (c == stall_start + stall_len - 1) acc_stall = issued;
    end
    @(negedge clock);
    I_Valid = 1'b0; I_WB_We = 1'b0; I_Ready = 1'b1; I_Re1 = 1'b0; I_Re2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_low, acc_stall, first_d, last_d, deliv, stale;
    reset = 1'b1; I_Valid = 1'b0; I_Re1 = 1'b0; I_Re2 = 1'b0;
    I_Index_Src1 = 6'd0; I_Index_Src2 = 6'd0; I_Tag = 8'h00;
    I_WB_We = 1'b0; I_WB_Index = 6'd0; I_WB_Data = 32'h0; I_Ready = 1'b1;

    // Preload the register file while the DUT is held in reset
    wb_write(6'd3, 32'h11);
    wb_write(6'd5, 32'h22);
    wb_write(6'd4, 32'h1000);
    wb_write(6'd9, 32'h5);
    wb_write(6'd0, 32'h77);
    wb_write(6'd7, 32'h3C);

    @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset O_Valid", 32'(O_Valid), 32'd0);
    check("reset O_Src1",  O_Src1,       32'd0);
    check("reset O_Src2",  O_Src2,       32'd0);
    check("reset O_Tag",   32'(O_Tag),   32'd0);
    check("reset O_Ready", 32'(O_Ready), 32'd1);

    //            re1   re2   i1     i2     tag    wmode wi     wd            e1            e2
    vt[0] = '{1'b1, 1'b1, 6'd3,  6'd5,  8'h07, 2'd0, 6'd0,  32'h0,        32'h11,       32'h22};
    vt[1] = '{1'b1, 1'b0, 6'd4,  6'd5,  8'h08, 2'd1, 6'd4,  32'hABCD,     32'hABCD,     32'h0};
    vt[2] = '{1'b0, 1'b1, 6'd3,  6'd9,  8'h09, 2'd0, 6'd0,  32'h0,        32'h0,        32'h5};
    vt[3] = '{1'b1, 1'b1, 6'd0,  6'd0,  8'h0A, 2'd0, 6'd0,  32'h0,        32'h77,       32'h77};
    vt[4] = '{1'b1, 1'b1, 6'd7,  6'd7,  8'h0B, 2'd1, 6'd7,  32'hDEAD,     32'hDEAD,     32'hDEAD};
    vt[5] = '{1'b1, 1'b1, 6'd3,  6'd5,  8'h0C, 2'd1, 6'd6,  32'h1,        32'h11,       32'h22};
    vt[6] = '{1'b1, 1'b0, 6'd4,  6'd0,  8'h0D, 2'd0, 6'd0,  32'h0,        32'hABCD,     32'h0};
    for (int i = 0; i < 7; i++) apply_vec(vt[i], $sformatf("vec%0d", i));

    // Write one cycle before issue is read from the file; one cycle after is not seen
    wb_write(6'd4, 32'h5555);
    apply_vec('{1'b1, 1'b0, 6'd4, 6'd0, 8'h0E, 2'd0, 6'd0, 32'h0,    32'h5555, 32'h0}, "wb_early");
    apply_vec('{1'b1, 1'b0, 6'd4, 6'd0, 8'h0F, 2'd2, 6'd4, 32'h6666, 32'h5555, 32'h0}, "wb_late");
    apply_vec('{1'b1, 1'b0, 6'd4, 6'd0, 8'h40, 2'd0, 6'd0, 32'h0,    32'h6666, 32'h0}, "wb_after");

    // Eight back-to-back issues with I_Ready held high
    st.delete();
    for (int i = 0; i < 8; i++) begin
      st.push_back('{1'b1, 1'b1, (i % 2 == 1) ? 6'd5 : 6'd3, 6'd0, 8'h10 + 8'(i), 2'd0, 6'd0, 32'h0,
                     (i % 2 == 1) ? 32'h22 : 32'h11, 32'h77});
    end
    run_stream(-10, 0, -1, 6'd0, 32'h0, rdy_low, acc_stall, first_d, last_d, deliv);
    check("b2b delivered",     32'(deliv),           32'd8);
    check("b2b O_Ready low",   32'(rdy_low),         32'd0);
    check("b2b first latency", 32'(first_d),         32'd2);
    check("b2b contiguous",    32'(last_d - first_d), 32'd7);

    // Output stalled for 5 cycles with 3 instructions; write to r5 during the stall
    st.delete();
    st.push_back('{1'b1, 1'b0, 6'd3, 6'd0, 8'h21, 2'd0, 6'd0, 32'h0, 32'h11, 32'h0});
    st.push_back('{1'b1, 1'b1, 6'd5, 6'd3, 8'h22, 2'd0, 6'd0, 32'h0, 32'h22, 32'h11});
    st.push_back('{1'b1, 1'b0, 6'd9, 6'd0, 8'h23, 2'd0, 6'd0, 32'h0, 32'h5,  32'h0});
    run_stream(0, 5, 2, 6'd5, 32'hBAD0, rdy_low, acc_stall, first_d, last_d, deliv);
    check("stall accepted",    32'(acc_stall), 32'd2);
    check("stall ready low",   32'(rdy_low),   32'd3);
    check("stall delivered",   32'(deliv),     32'd3);
    check("stall first deliv", 32'(first_d),   32'd5);

    // Fill S1 and S2, then reset mid-operation
    @(negedge clock);
    I_Ready = 1'b0; I_Valid = 1'b1; I_Re1 = 1'b1; I_Re2 = 1'b0; I_Index_Src1 = 6'd3; I_Tag = 8'h31;
    @(negedge clock);
    I_Tag = 8'h32;
    #1;
    check("fill second accept", 32'(O_Ready), 32'd1);
    @(negedge clock);
    I_Valid = 1'b0;
    #1;
    check("full O_Valid", 32'(O_Valid), 32'd1);
    check("full O_Ready", 32'(O_Ready), 32'd0);
    reset = 1'b1; I_Valid = 1'b1; I_Tag = 8'h33;
    #1;
    check("in reset O_RF_Re1", 32'(O_RF_Re1), 32'd0);
    @(negedge clock);
    reset = 1'b0; I_Valid = 1'b0; I_Re1 = 1'b0;
    #1;
    check("midreset O_Valid", 32'(O_Valid), 32'd0);
    check("midreset O_Src1",  O_Src1,       32'd0);
    check("midreset O_Src2",  O_Src2,       32'd0);
    check("midreset O_Tag",   32'(O_Tag),   32'd0);
    check("midreset O_Ready", 32'(O_Ready), 32'd1);
    I_Ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); #1;
      if (O_Valid) stale++;
    end
    check("no stale output after reset", 32'(stale), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
